// File: rtl/mu0_mem_responder.sv
// mu0_mem_responder: MU0 bus memory responder with wait states and registered ready/err pulses.
// Define MU0_MEM_PROTECT_EN to reject writes below PROT_LIMIT.
module mu0_mem_responder #(
  parameter int AW          = 12,
  parameter int DW          = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 1,
  parameter int PROT_LIMIT  = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          memrq,
  input  logic          rnw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          err,
  output logic [15:0]   acc_count
);
`ifdef MU0_MEM_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rnw_q, rnw_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic [15:0]   acc_q, acc_d;
  logic          accept, enter, in_range, prot, do_wr;
  logic [AW-1:0] a_addr;
  logic          a_rnw;
  logic [DW-1:0] a_wdata;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rnw_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = memrq ? (WAIT_CYCLES == 0 ? RESP : BUSY) : IDLE;
        cnt_d   = memrq ? 4'(WAIT_CYCLES) : cnt_q;
      end
      BUSY: begin
        state_d = cnt_q == 4'd1 ? RESP : BUSY;
        cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access commits on the accepting edge, so the live inputs are used then.
  always_comb begin
    accept   = state_q == IDLE && memrq;
    a_addr   = accept ? addr : addr_q;
    a_rnw    = accept ? rnw : rnw_q;
    a_wdata  = accept ? wdata : wdata_q;
    addr_d   = a_addr;
    rnw_d    = a_rnw;
    wdata_d  = a_wdata;
    enter    = state_d == RESP && state_q != RESP;
    in_range = 32'(a_addr) < DEPTH;
    prot     = PROT_EN && !a_rnw && 32'(a_addr) < PROT_LIMIT;
    do_wr    = enter && !a_rnw && in_range && !prot;
    rdata_d  = (enter && a_rnw) ? (in_range ? mem[a_addr[IW-1:0]] : '0) : rdata_q;
    ready_d  = enter;
    err_d    = enter && (!in_range || prot);
    acc_d    = acc_q + 16'(enter);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[a_addr[IW-1:0]] <= a_wdata;
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign acc_count = acc_q;
endmodule

// File: tb/tb_mu0_mem_responder.sv
// tb_mu0_mem_responder: three responders (1, 0, 3 wait states, 1024 words) checked against an access-level model.
module tb_mu0_mem_responder;
  localparam int WC[3] = '{1, 0, 3};
  localparam int DEPTH = 1024;
`ifdef MU0_MEM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memrq [3];
  logic        rnw [3];
  logic [11:0] addr [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ready [3];
  logic        err [3];
  logic [15:0] acc [3];

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] mdl [int];
  int accm [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mu0_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .memrq(memrq[g]), .rnw(rnw[g]), .addr(addr[g]),
      .wdata(wdata[g]), .rdata(rdata[g]), .ready(ready[g]), .err(err[g]), .acc_count(acc[g])
    );
  end

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, o, e);
    end
  endtask

  task automatic access(input int k, input bit r, input logic [11:0] a, input logic [15:0] d);
    int n;
    int key;
    bit ee;
    memrq[k] = 1'b1; rnw[k] = r; addr[k] = a; wdata[k] = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready[k] && n < 20);
    memrq[k] = 1'b0;
    key = k * 4096 + int'(a);
    ee = a >= DEPTH || (PROT && !r && a < 256);
    accm[k]++;
    chk($sformatf("ready_seen[%0d]", k), ready[k], 1);
    chk($sformatf("latency[%0d]", k), n, WC[k] + 1);
    chk($sformatf("err[%0d]@%h", k, a), err[k], ee);
    chk($sformatf("acc[%0d]", k), acc[k], accm[k] % 65536);
    if (r && a >= DEPTH) chk($sformatf("rdata_oor[%0d]", k), rdata[k], 0);
    else if (r && mdl.exists(key)) chk($sformatf("rdata[%0d]@%h", k, a), rdata[k], mdl[key]);
    if (!r && !ee) mdl[key] = d;
    @(posedge clk); #1;
    chk($sformatf("ready_pulse[%0d]", k), ready[k], 0);
  endtask

  initial begin
    int n;
    bit seen;
    for (int k = 0; k < 3; k++) begin
      memrq[k] = 0; rnw[k] = 0; addr[k] = 0; wdata[k] = 0; accm[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata[k], 0);
      chk("rst_ready", ready[k], 0);
      chk("rst_err", err[k], 0);
      chk("rst_acc", acc[k], 0);
    end
    rst_n = 1'b1;
    access(0, 0, 12'h300, 16'h1234);
    access(0, 1, 12'h300, 16'h0);
    chk("wr_rd_value", rdata[0], 16'h1234);
    chk("wr_rd_acc", acc[0], 2);
    access(1, 0, 12'h301, 16'hBEEF);
    access(1, 1, 12'h301, 16'h0);
    chk("zw_value", rdata[1], 16'hBEEF);
    memrq[1] = 1'b1; rnw[1] = 1'b1; addr[1] = 12'h301;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready[1] && n < 20);
    chk("b2b_first", n, 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready[1] && n < 20);
    memrq[1] = 1'b0;
    accm[1] += 2;
    chk("b2b_gap", n, 2);
    chk("b2b_rdata", rdata[1], 16'hBEEF);
    chk("b2b_acc", acc[1], accm[1]);
    @(posedge clk); #1;
    access(0, 0, 12'h000, 16'h5A5A);
    access(0, 1, 12'h800, 16'h0);
    access(0, 0, 12'h800, 16'hAAAA);
    access(0, 1, 12'h000, 16'h0);
    chk("oor_keep", rdata[0], 16'h5A5A);
    access(0, 0, 12'h010, 16'h0123);
    access(0, 0, 12'h010, 16'hFFFF);
    access(0, 1, 12'h010, 16'h0);
    if (!PROT) chk("unprot_wr", rdata[0], 16'hFFFF);
    access(2, 0, 12'h310, 16'h1111);
    memrq[2] = 1'b1; rnw[2] = 1'b0; addr[2] = 12'h310; wdata[2] = 16'h5555;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    memrq[2] = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) accm[k] = 0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; seen |= ready[2]; end
    chk("mid_rst_no_ready", seen, 0);
    chk("mid_rst_acc", acc[2], 0);
    chk("mid_rst_rdata", rdata[2], 0);
    access(2, 1, 12'h310, 16'h0);
    chk("mid_rst_old", rdata[2], 16'h1111);
    for (int i = 0; i < 40; i++) begin
      int k;
      int b;
      logic [11:0] a;
      k = int'($urandom_range(0, 2));
      b = int'($urandom_range(0, 3));
      a = b == 0 ? 12'($urandom_range(1024, 4095)) : b == 1 ? 12'($urandom_range(0, 31)) : 12'(12'h300 + $urandom_range(0, 15));
      access(k, 1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
